// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Segment patterns are active-high {g,f,e,d,c,b,a}; polarity is applied at the pins.
package seven_seg_pkg;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

  // Converts a logical "on" into the pin level for the selected polarity.
  function automatic logic drive_level(input logic on, input logic active_low);
    return on ^ active_low;
  endfunction

endpackage

// File: rtl/hex_to_seven_segment.sv
// Combinational hex nibble to active-high seven-segment pattern {g,f,e,d,c,b,a}.
module hex_to_seven_segment
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_0;
    case (nibble_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
      default: seg_o = SEG_0;
    endcase
  end

endmodule

// File: rtl/seven_segment_scan_controller.sv
// Multiplexed seven-segment scanner with double-buffered value load, inter-digit
// blanking and leading-zero suppression. All pin outputs are registered.
module seven_segment_scan_controller
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int TICK_DIV     = 100000,
  parameter int BLANK_CYCLES = 16,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic [NUM_DIGITS-1:0]   dots_i,
  input  logic                    value_valid_i,
  output logic                    value_ready_o,
  input  logic                    blank_zeros_i,
  output logic [NUM_DIGITS-1:0]   anodes_o,
  output logic [6:0]              segments_o,
  output logic                    dp_o,
  output logic                    frame_done_o
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int VW = 4 * NUM_DIGITS;
  localparam logic [CW-1:0] CNT_LAST  = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic          AL        = (ACTIVE_LOW != 0);

  logic [CW-1:0]         slot_cnt_q, slot_cnt_d;
  logic [IW-1:0]         digit_idx_q, digit_idx_d;
  scan_state_e           state_q, state_d;
  logic [VW-1:0]         pend_q, pend_d, disp_q, disp_d;
  logic [NUM_DIGITS-1:0] pend_dots_q, pend_dots_d, disp_dots_q, disp_dots_d;
  logic                  ready_q, ready_d;
  logic [NUM_DIGITS-1:0] anodes_q, anodes_d;
  logic [6:0]            segments_q, segments_d;
  logic                  dp_q, dp_d;
  logic                  frame_done_q, frame_done_d;

  logic                  wrap, boundary, suppress, lit;
  logic [3:0]            nibble;
  logic [6:0]            seg_act;

  hex_to_seven_segment u_decode (
    .nibble_i (nibble),
    .seg_o    (seg_act)
  );

  // Outputs are computed from the next counter/display values so the registered
  // pins line up with the slot that the counters are entering.
  always_comb begin
    wrap        = (slot_cnt_q == CNT_LAST);
    boundary    = wrap && (digit_idx_q == IDX_LAST);
    slot_cnt_d  = wrap ? '0 : slot_cnt_q + 1'b1;
    digit_idx_d = digit_idx_q;
    if (wrap) digit_idx_d = (digit_idx_q == IDX_LAST) ? '0 : digit_idx_q + 1'b1;
    state_d = (slot_cnt_d < BLANK_LIM) ? BLANK : DRIVE;

    pend_d      = pend_q;
    pend_dots_d = pend_dots_q;
    disp_d      = disp_q;
    disp_dots_d = disp_dots_q;
    ready_d     = ready_q;
    if (boundary && !ready_q) begin
      disp_d      = pend_q;
      disp_dots_d = pend_dots_q;
      ready_d     = 1'b1;
    end
    if (value_valid_i && ready_q) begin
      pend_d      = value_i;
      pend_dots_d = dots_i;
      ready_d     = 1'b0;
    end

    nibble   = disp_d[4*int'(digit_idx_d) +: 4];
    suppress = 1'b0;
    if (blank_zeros_i && (digit_idx_d != '0))
      suppress = ((disp_d >> (4*int'(digit_idx_d))) == '0);
    lit = (state_d == DRIVE) && !suppress;

    for (int k = 0; k < NUM_DIGITS; k++)
      anodes_d[k] = drive_level(lit && (digit_idx_d == IW'(k)), AL);
    for (int s = 0; s < 7; s++)
      segments_d[s] = drive_level(lit && seg_act[s], AL);
    dp_d         = drive_level(lit && disp_dots_d[digit_idx_d], AL);
    frame_done_d = (slot_cnt_d == CNT_LAST) && (digit_idx_d == IDX_LAST);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_cnt_q   <= '0;
      digit_idx_q  <= '0;
      state_q      <= BLANK;
      pend_q       <= '0;
      pend_dots_q  <= '0;
      disp_q       <= '0;
      disp_dots_q  <= '0;
      ready_q      <= 1'b1;
      anodes_q     <= {NUM_DIGITS{AL}};
      segments_q   <= {7{AL}};
      dp_q         <= AL;
      frame_done_q <= 1'b0;
    end else begin
      slot_cnt_q   <= slot_cnt_d;
      digit_idx_q  <= digit_idx_d;
      state_q      <= state_d;
      pend_q       <= pend_d;
      pend_dots_q  <= pend_dots_d;
      disp_q       <= disp_d;
      disp_dots_q  <= disp_dots_d;
      ready_q      <= ready_d;
      anodes_q     <= anodes_d;
      segments_q   <= segments_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign value_ready_o = ready_q;
  assign anodes_o      = anodes_q;
  assign segments_o    = segments_q;
  assign dp_o          = dp_q;
  assign frame_done_o  = frame_done_q;

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Directed bench for the scan controller at NUM_DIGITS=4, TICK_DIV=8, BLANK_CYCLES=2, active-low.
module tb_seven_segment_scan_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  dots = '0;
  logic        valid = 1'b0;
  logic        ready;
  logic        blank_zeros = 1'b0;
  logic [3:0]  anodes;
  logic [6:0]  segments;
  logic        dp;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  seven_segment_scan_controller #(
    .NUM_DIGITS(4), .TICK_DIV(8), .BLANK_CYCLES(2), .ACTIVE_LOW(1)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .value_i       (value),
    .dots_i        (dots),
    .value_valid_i (valid),
    .value_ready_o (ready),
    .blank_zeros_i (blank_zeros),
    .anodes_o      (anodes),
    .segments_o    (segments),
    .dp_o          (dp),
    .frame_done_o  (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pins in idle state: everything off, ready, no frame pulse.
  task automatic chk_off(input string tag);
    chk(tag, {19'd0, anodes, segments, dp, ready, frame_done}, {19'd0, 4'hF, 7'h7F, 1'b1, 1'b1, 1'b0});
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] d);
    @(negedge clk);
    chk("ready_before_load", 32'(ready), 32'd1);
    value = v; dots = d; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    chk("ready_after_load", 32'(ready), 32'd0);
  endtask

  task automatic wait_frame_done();
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (frame_done) seen = 1;
    end
    chk("frame_done_timeout", 32'(seen), 32'd1);
  endtask

  // Checks one whole 32-cycle frame starting from the slot after a boundary.
  // segs_exp holds the active-low pattern of digit k at [7k+:7].
  task automatic check_frame(input string tag, input logic [27:0] segs_exp,
                             input logic [3:0] on_exp, input logic [3:0] dots_exp);
    logic [3:0] one = 4'b0001;
    for (int k = 0; k < 32; k++) begin
      int d = k / 8;
      int s = k % 8;
      logic lit;
      logic [3:0] e_an;
      logic [6:0] e_seg;
      logic e_dp;
      @(negedge clk);
      lit   = (s >= 2) && on_exp[d];
      e_an  = lit ? ~(one << d) : 4'hF;
      e_seg = lit ? segs_exp[7*d +: 7] : 7'h7F;
      e_dp  = lit ? ~dots_exp[d] : 1'b1;
      chk($sformatf("%s_d%0d_s%0d", tag, d, s),
          {19'd0, anodes, segments, dp, frame_done},
          {19'd0, e_an, e_seg, e_dp, (k == 31)});
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_off("reset_state");
    rst = 1'b0;

    load(16'h12AF, 4'b0001);
    wait_frame_done();
    check_frame("f12AF", {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110}, 4'b1111, 4'b0001);
    chk("ready_after_commit", 32'(ready), 32'd1);

    load(16'h1111, 4'b0000);
    value = 16'h2222; valid = 1'b1;
    repeat (3) @(negedge clk);
    valid = 1'b0;
    chk("ready_while_ignored", 32'(ready), 32'd0);
    wait_frame_done();
    check_frame("f1111", {4{7'b1111001}}, 4'b1111, 4'b0000);

    blank_zeros = 1'b1;
    load(16'h0005, 4'b0000);
    wait_frame_done();
    check_frame("f0005", {7'h7F, 7'h7F, 7'h7F, 7'b0010010}, 4'b0001, 4'b0000);

    load(16'h0000, 4'b0000);
    wait_frame_done();
    check_frame("f0000b", {7'h7F, 7'h7F, 7'h7F, 7'b1000000}, 4'b0001, 4'b0000);

    // Now sitting on a boundary cycle: capture here must wait a full frame.
    chk("on_boundary", 32'(frame_done), 32'd1);
    value = 16'h8888; dots = 4'b0000; valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
    check_frame("f_boundary_old", {7'h7F, 7'h7F, 7'h7F, 7'b1000000}, 4'b0001, 4'b0000);
    check_frame("f8888", {4{7'b0000000}}, 4'b1111, 4'b0000);

    blank_zeros = 1'b0;
    load(16'h3333, 4'b1111);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_off("mid_reset_1");
    @(negedge clk);
    chk_off("mid_reset_2");
    rst = 1'b0;
    wait_frame_done();
    check_frame("f_after_reset", {4{7'b1000000}}, 4'b1111, 4'b0000);
    chk("ready_after_reset", 32'(ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
